codec_serial_link: RTL and testbench
====================================

Name: codec_serial_link

Overview:
- Codec-side serial interface for the audio sample path: the block at the other end of the `sample_req` / `sample_end` / `audio_output` / `audio_input` handshake used by the effects/mixer stage.
- Generates bit clock and LR clock, requests one 16-bit DAC sample per frame and serializes it MSB-first, left-justified, to the codec.
- Deserializes the codec ADC left-channel word and presents it with a one-cycle `sample_end` strobe.
- Mono: the same DAC word is sent in both channel slots.

Parameters:
- SLOT_BITS, 16, bits per channel slot and sample width; frame = 2*SLOT_BITS bit clocks.
- BCLK_HALF, 4, clk cycles per bclk half-period; must be >= 3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  enable; low = idle and outputs quiet.
- audio_output  in  SLOT_BITS  DAC sample from the mixer.
- sample_req  out  1  one-cycle pulse; mixer must update `audio_output`.
- audio_input  out  SLOT_BITS  latest ADC left-channel sample.
- sample_end  out  1  one-cycle pulse; `audio_input` was just updated.
- aud_bclk  out  1  codec bit clock.
- aud_lrck  out  1  codec LR clock; 1 = left slot.
- aud_dacdat  out  1  serial DAC data.
- aud_adcdat  in  1  serial ADC data.

Behaviour:
- Reset (async, reset_n=0):
  - `aud_bclk`, `aud_lrck`, `aud_dacdat`, `sample_req`, `sample_end` = 0.
  - `audio_input` = 0, DAC hold register = 0, `div_cnt` = 0, `bit_cnt` = 2*SLOT_BITS-1, state IDLE.
- States: IDLE, RUN.
  - IDLE: counters held at their reset values; bclk/lrck/dacdat low; no pulses.
  - IDLE -> RUN: first cycle with run=1. `sample_req` pulses in that same cycle.
  - RUN -> IDLE: any cycle with run=0. Counters, bclk, lrck and dacdat return to reset values on the next edge. Any partial ADC word is discarded. `audio_input` and the hold register are kept.
- Bit clock:
  - `div_cnt` counts 0..BCLK_HALF-1.
  - On wrap, `aud_bclk` toggles; the first toggle after IDLE is rising.
  - bclk period = 2*BCLK_HALF clk.
- Falling bclk edge:
  - `bit_cnt` increments mod 2*SLOT_BITS.
  - On the wrap to 0 (frame start), the DAC shift register loads from the hold register.
  - `aud_dacdat` = shift[SLOT_BITS-1 - (bit_cnt mod SLOT_BITS)], i.e. MSB first, reloaded from hold at the start of each slot.
  - `aud_lrck` = 1 when `bit_cnt` < SLOT_BITS, else 0.
  - All three are registered and change in the same clk cycle as the bclk fall.
- Sample request:
  - `sample_req` pulses for 1 cycle coincident with the falling edge that sets `bit_cnt` to 2*SLOT_BITS-1.
  - Also pulses on IDLE->RUN, as above.
  - The hold register captures `audio_output` exactly 2 clk cycles after each `sample_req` pulse. BCLK_HALF >= 3 guarantees the capture precedes frame start.
- ADC path:
  - On each rising bclk edge with `bit_cnt` < SLOT_BITS, `aud_adcdat` shifts into the ADC shift register, MSB first.
  - On the rising edge where `bit_cnt` = SLOT_BITS-1, the completed word is written to `audio_input`, with `sample_end` = 1 for that one cycle.
  - Right-slot ADC bits are ignored.
  - The first rising edge after IDLE (`bit_cnt` = 2*SLOT_BITS-1) shifts nothing.
- Simultaneity:
  - `sample_req` and `sample_end` never coincide: different bclk phases.
  - run falling in the same cycle as a pending hold capture: the capture still happens.
- Latency: `audio_output` sampled at `sample_req`+2 first appears on `aud_dacdat` at the next frame-start falling edge.
- Arithmetic: counters only, fixed widths, no saturation.

Test Plan:
1. Reset/idle: reset_n=0 then 1 with run=0 for 100 cycles -> all outputs 0; no toggles or pulses.
2. Start-up timing: defaults, run=1 at cycle T:
   - `sample_req` at T.
   - bclk rises at T+4, falls at T+8 (frame start, lrck=1).
   - Next `sample_req` at T+8+31*8 = T+256; `sample_req` period 256 cycles.
3. DAC serialization: mixer returns 16'hA5C3 two cycles after each `sample_req` -> left slot `aud_dacdat` sampled at bclk rising = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; right slot identical; lrck 16 bclk high / 16 low.
4. ADC capture: model drives left word 16'h8001 and right word 16'hFFFF -> `sample_end` single pulse at the 16th left rising edge; `audio_input` = 16'h8001; right word ignored.
5. Mid-frame stop: drop run at `bit_cnt` = 9 -> next cycle bclk/lrck/dacdat = 0, no `sample_end`, `audio_input` unchanged; re-raise run -> sequence restarts exactly as in scenario 2.
6. Async reset mid-frame: reset_n=0 between clk edges during the left slot -> outputs 0 immediately, with no clk edge required; `audio_input` = 0.

Source files
------------

// File: rtl/codec_serial_link.sv
// codec_serial_link: codec-side bit/LR clock generator,
// mono DAC serializer and left-channel ADC deserializer.
module codec_serial_link #(
  parameter int SLOT_BITS = 16,
  parameter int BCLK_HALF = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [SLOT_BITS-1:0] audio_output,
  output logic                 sample_req,
  output logic [SLOT_BITS-1:0] audio_input,
  output logic                 sample_end,
  output logic                 aud_bclk,
  output logic                 aud_lrck,
  output logic                 aud_dacdat,
  input  logic                 aud_adcdat
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int BW = $clog2(FRAME);
  localparam int SW = $clog2(SLOT_BITS);
  localparam int DW = $clog2(BCLK_HALF);

  localparam logic [BW-1:0] LAST = BW'(FRAME - 1);
  localparam logic [BW-1:0] SLOT = BW'(SLOT_BITS);
  localparam logic [BW-1:0] SLOT_LAST = BW'(SLOT_BITS - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(BCLK_HALF - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]           state;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [SLOT_BITS-1:0] hold;
  logic [SLOT_BITS-1:0] dac_sr;
  logic [SLOT_BITS-2:0] adc_sr;
  logic                 req_d;

  logic                 active;
  logic                 wrap;
  logic                 rise;
  logic                 fall;
  logic [BW-1:0]        bit_nxt;
  logic                 lrck_nxt;
  logic [SW-1:0]        slot_pos;
  logic [SW-1:0]        dac_idx;
  logic [SLOT_BITS-1:0] dac_word;
  logic [SLOT_BITS-1:0] adc_nxt;

  assign active   = (state == RUN) && run;
  assign wrap     = div_cnt == HALF_LAST;
  assign rise     = active && wrap && !aud_bclk;
  assign fall     = active && wrap && aud_bclk;
  assign bit_nxt  = (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
  assign lrck_nxt = bit_nxt < SLOT;
  assign slot_pos = SW'(lrck_nxt ? bit_nxt : bit_nxt - SLOT);
  assign dac_idx  = SW'(SLOT_BITS - 1) - slot_pos;
  assign dac_word = (bit_nxt == '0) ? hold : dac_sr;
  assign adc_nxt  = {adc_sr, aud_adcdat};

  // State, bit clock divider, frame counter and DAC/LR outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= LAST;
      aud_bclk   <= 1'b0;
      aud_lrck   <= 1'b0;
      aud_dacdat <= 1'b0;
      sample_req <= 1'b0;
      dac_sr     <= '0;
    end else begin
      sample_req <= 1'b0;
      if (!run) begin
        state      <= IDLE;
        div_cnt    <= '0;
        bit_cnt    <= LAST;
        aud_bclk   <= 1'b0;
        aud_lrck   <= 1'b0;
        aud_dacdat <= 1'b0;
      end else if (state == IDLE) begin
        state      <= RUN;
        sample_req <= 1'b1;
      end else begin
        div_cnt <= wrap ? '0 : div_cnt + 1'b1;
        if (wrap) aud_bclk <= !aud_bclk;
        if (fall) begin
          bit_cnt    <= bit_nxt;
          aud_lrck   <= lrck_nxt;
          aud_dacdat <= dac_word[dac_idx];
          dac_sr     <= dac_word;
          sample_req <= bit_nxt == LAST;
        end
      end
    end
  end

  // Mixer word captured two cycles after each request, run-independent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_d <= 1'b0;
      hold  <= '0;
    end else begin
      req_d <= sample_req;
      if (req_d) hold <= audio_output;
    end
  end

  // Left-slot ADC shift on rising bclk, publish on the last left bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adc_sr      <= '0;
      audio_input <= '0;
      sample_end  <= 1'b0;
    end else begin
      sample_end <= 1'b0;
      if (!run) begin
        adc_sr <= '0;
      end else if (rise && (bit_cnt < SLOT)) begin
        adc_sr <= adc_nxt[SLOT_BITS-2:0];
        if (bit_cnt == SLOT_LAST) begin
          audio_input <= adc_nxt;
          sample_end  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_serial_link.sv
// tb_codec_serial_link: directed bench with mixer and
// codec ADC models around codec_serial_link.
module tb_codec_serial_link;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] audio_output;
  logic        sample_req;
  logic [15:0] audio_input;
  logic        sample_end;
  logic        aud_bclk;
  logic        aud_lrck;
  logic        aud_dacdat;
  logic        aud_adcdat = 1'b0;

  codec_serial_link #(
    .SLOT_BITS(16),
    .BCLK_HALF(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .audio_output(audio_output),
    .sample_req  (sample_req),
    .audio_input (audio_input),
    .sample_end  (sample_end),
    .aud_bclk    (aud_bclk),
    .aud_lrck    (aud_lrck),
    .aud_dacdat  (aud_dacdat),
    .aud_adcdat  (aud_adcdat)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // mixer: valid word only 2..3 cycles after a request
  logic [15:0] mix_val = 16'h1234;
  logic rq1 = 1'b0;
  logic rq2 = 1'b0;
  logic rq3 = 1'b0;
  always @(negedge clk) begin
    rq1 <= sample_req;
    rq2 <= rq1;
    rq3 <= rq2;
  end
  assign audio_output = (rq2 || rq3) ? mix_val : 16'h0F0F;

  // codec ADC: new bit after each bclk fall, MSB first
  logic [15:0] adc_l = 16'h3C5A;
  logic [15:0] adc_r = 16'hFFFF;
  logic [3:0]  aidx = 4'd0;
  logic        pb = 1'b0;
  logic        pl = 1'b0;
  always @(negedge clk) begin
    if (pb && !aud_bclk) begin
      if (aud_lrck != pl) aidx = 4'd0;
      else aidx = aidx + 4'd1;
      aud_adcdat = aud_lrck ? adc_l[4'd15 - aidx]
                            : adc_r[4'd15 - aidx];
    end
    pb = aud_bclk;
    pl = aud_lrck;
  end

  int          req_cnt;
  int          req_k0;
  int          req_k1;
  int          end_cnt;
  int          end_k0;
  int          rise_k;
  int          fall_k;
  logic        lrck_f;
  logic [31:0] dac_bits;
  logic [31:0] lr_bits;
  int          nrise;

  // raise run at a negedge and log n cycles of activity
  task automatic start_run(input int n);
    logic pbc;
    pbc = 1'b0;
    req_cnt = 0; req_k0 = -1; req_k1 = -1;
    end_cnt = 0; end_k0 = -1;
    rise_k = -1; fall_k = -1; lrck_f = 1'b0;
    dac_bits = '0; lr_bits = '0; nrise = 0;
    run = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sample_req) begin
        if (req_cnt == 0) req_k0 = k;
        else if (req_cnt == 1) req_k1 = k;
        req_cnt++;
      end
      if (sample_end) begin
        if (end_cnt == 0) end_k0 = k;
        end_cnt++;
      end
      if (!pbc && aud_bclk) begin
        if (rise_k < 0) rise_k = k;
        else if (nrise < 32) begin
          dac_bits = {dac_bits[30:0], aud_dacdat};
          lr_bits  = {lr_bits[30:0], aud_lrck};
          nrise++;
        end
      end
      if (pbc && !aud_bclk && fall_k < 0) begin
        fall_k = k;
        lrck_f = aud_lrck;
      end
      pbc = aud_bclk;
    end
  endtask

  logic [4:0]  acc;
  logic [15:0] ai_acc;
  int          se_cnt;

  initial begin
    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({aud_bclk, aud_lrck, aud_dacdat,
                           sample_req, sample_end}), 32'd0);
    check("rst_ain", 32'(audio_input), 32'd0);
    reset_n = 1'b1;
    acc = '0;
    ai_acc = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = acc | {aud_bclk, aud_lrck, aud_dacdat,
                   sample_req, sample_end};
      ai_acc = ai_acc | audio_input;
    end
    check("idle_outs", 32'(acc), 32'd0);
    check("idle_ain", 32'(ai_acc), 32'd0);

    // start-up timing, first frame carries 16'h1234
    start_run(300);
    check("s2_req0", 32'(req_k0), 32'd0);
    check("s2_rise", 32'(rise_k), 32'd4);
    check("s2_fall", 32'(fall_k), 32'd8);
    check("s2_lrck", 32'(lrck_f), 32'd1);
    check("s2_req1", 32'(req_k1), 32'd256);
    check("s2_reqn", 32'(req_cnt), 32'd2);
    check("s2_dac", dac_bits, 32'h1234_1234);
    check("s2_end", 32'(end_k0), 32'd132);
    check("s2_ain", 32'(audio_input), 32'h3C5A);
    run = 1'b0;
    repeat (10) @(negedge clk);
    check("s2_stop", 32'({aud_bclk, aud_lrck, aud_dacdat}),
          32'd0);

    // DAC serialization and ADC capture
    mix_val = 16'hA5C3;
    adc_l = 16'h8001;
    adc_r = 16'hFFFF;
    start_run(400);
    check("s3_dac", dac_bits, 32'hA5C3_A5C3);
    check("s3_lrck", lr_bits, 32'hFFFF_0000);
    check("s3_reqn", 32'(req_cnt), 32'd2);
    check("s4_end", 32'(end_k0), 32'd132);
    check("s4_endn", 32'(end_cnt), 32'd2);
    check("s4_ain", 32'(audio_input), 32'h8001);
    run = 1'b0;
    repeat (10) @(negedge clk);

    // stop mid-frame while bit 9 of the left slot is out
    mix_val = 16'hFFFF;
    adc_l = 16'h1111;
    start_run(85);
    check("s5_pre", 32'({aud_bclk, aud_lrck, aud_dacdat}),
          32'd7);
    run = 1'b0;
    @(negedge clk);
    check("s5_quiet", 32'({aud_bclk, aud_lrck, aud_dacdat}),
          32'd0);
    se_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_end) se_cnt++;
    end
    check("s5_noend", 32'(se_cnt), 32'd0);
    check("s5_ain", 32'(audio_input), 32'h8001);
    start_run(140);
    check("s5_req0", 32'(req_k0), 32'd0);
    check("s5_rise", 32'(rise_k), 32'd4);
    check("s5_fall", 32'(fall_k), 32'd8);
    check("s5_lrck", 32'(lrck_f), 32'd1);
    check("s5_end", 32'(end_k0), 32'd132);
    check("s5_ain2", 32'(audio_input), 32'h1111);
    run = 1'b0;
    repeat (4) @(negedge clk);

    // async reset in the left slot, between clock edges
    start_run(50);
    check("s6_pre", 32'({aud_lrck, audio_input}),
          32'h1_1111);
    #2 reset_n = 1'b0;
    #1;
    check("s6_outs", 32'({aud_bclk, aud_lrck, aud_dacdat,
                          sample_req, sample_end}), 32'd0);
    check("s6_ain", 32'(audio_input), 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
